useq_fifo_bridge: RTL

Parametrised I/O bridge between a host (fabric logic or a UART front end) and one useq microsequencer core.
- Replaces the ad-hoc per-demo glue: reset stretcher, tick source, tied-off FIFO strobes.
- Provides two real FIFOs: host->useq (feeds useq read_fifo/fifo_out/fifo_empty) and useq->host (fed by useq write_fifo/fifo_in).
- Also provides a generated reset for the core and a programmable tick, plus sticky overflow/underflow flags per direction.

---
 rtl/useq_fifo_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/useq_fifo_bridge.sv
// useq_fifo_bridge: host <-> useq I/O glue. Generates a stretched core reset,
// a programmable square-wave tick, and two first-word-fall-through FIFOs
// (host->useq and useq->host) with sticky overflow/underflow flags.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   useq_rst_n               stretched active-low reset for the useq core
//   tick                     square wave, period 2*TICK_DIV cycles
//   host_wr/host_wdata       push into H2U; host_full = H2U full
//   host_rd/host_rdata       pop U2H head; host_empty = U2H empty
//   useq_read_fifo           pop H2U head (useq_fifo_out); useq_fifo_empty
//   useq_write_fifo          push useq_fifo_in into U2H
//   h2u_level, u2h_level     FIFO occupancy 0..DEPTH
//   err_flags                sticky {u2h_unf, u2h_ovf, h2u_unf, h2u_ovf}
module useq_fifo_bridge #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RST_STRETCH = 4,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      useq_rst_n,
  output logic                      tick,
  input  logic                      host_wr,
  input  logic [DATA_W-1:0]         host_wdata,
  output logic                      host_full,
  input  logic                      host_rd,
  output logic [DATA_W-1:0]         host_rdata,
  output logic                      host_empty,
  input  logic                      useq_read_fifo,
  output logic [DATA_W-1:0]         useq_fifo_out,
  output logic                      useq_fifo_empty,
  input  logic                      useq_write_fifo,
  input  logic [DATA_W-1:0]         useq_fifo_in,
  output logic [$clog2(DEPTH):0]    h2u_level,
  output logic [$clog2(DEPTH):0]    u2h_level,
  output logic [3:0]                err_flags
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LW  = PW + 1;
  localparam int unsigned SW  = $clog2(RST_STRETCH + 1);
  localparam int unsigned DW  = $clog2(TICK_DIV) + 1;
  localparam int unsigned H2U = 0;
  localparam int unsigned U2H = 1;

  logic [SW-1:0]     stretch_cnt;
  logic [DW-1:0]     tick_div;

  logic [DATA_W-1:0] mem     [2][DEPTH];
  logic [PW-1:0]     wr_ptr  [2];
  logic [PW-1:0]     rd_ptr  [2];
  logic [LW-1:0]     level   [2];
  logic              full_q  [2];
  logic              empty_q [2];
  logic [DATA_W-1:0] head_q  [2];

  logic              wr_c      [2];
  logic              rd_c      [2];
  logic [DATA_W-1:0] wdata_c   [2];
  logic              wr_ok_c   [2];
  logic              rd_ok_c   [2];
  logic [PW-1:0]     rd_nxt_c  [2];
  logic [LW-1:0]     lvl_nxt_c [2];
  logic [DATA_W-1:0] head_nxt_c[2];

  // Reset stretcher: count edges out of reset, saturate once released
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_cnt <= '0;
      useq_rst_n  <= 1'b0;
    end else if (!useq_rst_n) begin
      stretch_cnt <= stretch_cnt + SW'(1);
      useq_rst_n  <= (stretch_cnt == SW'(RST_STRETCH - 1));
    end
  end

  // Tick divider: toggle tick each time the divider wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_div <= '0;
      tick     <= 1'b0;
    end else if (tick_div == DW'(TICK_DIV - 1)) begin
      tick_div <= '0;
      tick     <= ~tick;
    end else begin
      tick_div <= tick_div + DW'(1);
    end
  end

  // Per-direction accept decisions and next-state values
  always_comb begin
    wr_c[H2U]    = host_wr;
    rd_c[H2U]    = useq_read_fifo;
    wdata_c[H2U] = host_wdata;
    wr_c[U2H]    = useq_write_fifo;
    rd_c[U2H]    = host_rd;
    wdata_c[U2H] = useq_fifo_in;
    for (int d = 0; d < 2; d++) begin
      // full blocks writes even when a read is accepted the same cycle
      wr_ok_c[d]   = wr_c[d] && !full_q[d];
      rd_ok_c[d]   = rd_c[d] && !empty_q[d];
      rd_nxt_c[d]  = rd_ptr[d] + PW'(rd_ok_c[d]);
      lvl_nxt_c[d] = level[d] + LW'(wr_ok_c[d]) - LW'(rd_ok_c[d]);
      // New head is the word being written if it lands on the next read slot
      if (wr_ok_c[d] && (wr_ptr[d] == rd_nxt_c[d])) begin
        head_nxt_c[d] = wdata_c[d];
      end else begin
        head_nxt_c[d] = mem[d][rd_nxt_c[d]];
      end
    end
  end

  // FIFO pointers, occupancy, registered flags and head word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        wr_ptr[d]  <= '0;
        rd_ptr[d]  <= '0;
        level[d]   <= '0;
        full_q[d]  <= 1'b0;
        empty_q[d] <= 1'b1;
        head_q[d]  <= '0;
      end
      err_flags <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        wr_ptr[d]  <= wr_ptr[d] + PW'(wr_ok_c[d]);
        rd_ptr[d]  <= rd_nxt_c[d];
        level[d]   <= lvl_nxt_c[d];
        full_q[d]  <= (lvl_nxt_c[d] == LW'(DEPTH));
        empty_q[d] <= (lvl_nxt_c[d] == '0);
        head_q[d]  <= head_nxt_c[d];
      end
      err_flags <= err_flags | {host_rd         & empty_q[U2H],
                                useq_write_fifo & full_q[U2H],
                                useq_read_fifo  & empty_q[H2U],
                                host_wr         & full_q[H2U]};
    end
  end

  // Storage array, contents not reset
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_ok_c[d]) mem[d][wr_ptr[d]] <= wdata_c[d];
    end
  end

  assign host_full       = full_q[H2U];
  assign useq_fifo_empty = empty_q[H2U];
  assign useq_fifo_out   = head_q[H2U];
  assign h2u_level       = level[H2U];
  assign host_empty      = empty_q[U2H];
  assign host_rdata      = head_q[U2H];
  assign u2h_level       = level[U2H];

endmodule
